// File: rtl/mem_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  localparam int ADR_W    = 16;
  localparam int DAT_W    = 16;
  localparam int MAX_CORE = 8;

  // First set bit of req scanning ptr, ptr+1, ... wrapping at ncore.
  function automatic logic [2:0] rr_pick(input logic [MAX_CORE-1:0] req,
                                         input logic [2:0] ptr,
                                         input int ncore);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CORE; i++) begin
      idx = 3'((int'(ptr) + i) % ncore);
      if (i < ncore && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/lock_table.sv
// Lock table shared by all cores: per-entry valid/owner, unlock-before-acquire,
// lowest index wins a race, one lock_ac pulse per lock_en assertion.
module lock_table
  import mem_arb_pkg::*;
#(
  parameter int NCORE  = 2,
  parameter int LOCK_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCORE*LOCK_W-1:0] lock_adr,
  input  logic [NCORE-1:0]        lock_en,
  input  logic [NCORE-1:0]        unlock_en,
  output logic [NCORE-1:0]        lock_ac
);
  localparam int DEPTH = 2 ** LOCK_W;
  localparam int ID_W  = $clog2(NCORE);

  logic [DEPTH-1:0] valid, valid_d;
  logic [ID_W-1:0]  owner   [DEPTH];
  logic [ID_W-1:0]  owner_d [DEPTH];
  logic [NCORE-1:0] grant;
  logic [NCORE-1:0] served;

  always_comb begin
    logic [LOCK_W-1:0] a;
    a       = '0;
    valid_d = valid;
    owner_d = owner;
    grant   = '0;
    for (int i = 0; i < NCORE; i++) begin
      a = lock_adr[i*LOCK_W +: LOCK_W];
      if (unlock_en[i] && valid_d[a] && owner_d[a] == ID_W'(i))
        valid_d[a] = 1'b0;
    end
    // Ascending scan: once a lower core takes an entry, higher cores see it owned.
    for (int i = 0; i < NCORE; i++) begin
      a = lock_adr[i*LOCK_W +: LOCK_W];
      if (lock_en[i] && (!valid_d[a] || owner_d[a] == ID_W'(i))) begin
        valid_d[a] = 1'b1;
        owner_d[a] = ID_W'(i);
        grant[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= '0;
      served  <= '0;
      lock_ac <= '0;
      for (int e = 0; e < DEPTH; e++) owner[e] <= '0;
    end else begin
      valid   <= valid_d;
      owner   <= owner_d;
      served  <= lock_en & (served | grant);
      lock_ac <= grant & ~served;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for one single-port memory plus the shared lock table.
//   state  | meaning
//   IDLE   | wait for a request, grant round-robin and latch it
//   ACCESS | drive memory enables for MEM_LAT cycles, capture read data
//   DONE   | pulse ac for the granted core, advance rr pointer
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCORE   = 2,
  parameter int MEM_LAT = 2,
  parameter int LOCK_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCORE-1:0]        req_read,
  input  logic [NCORE-1:0]        req_write,
  input  logic [NCORE*ADR_W-1:0]  req_adr,
  input  logic [NCORE*DAT_W-1:0]  req_wdat,
  output logic [NCORE-1:0]        ac,
  output logic [DAT_W-1:0]        rdat,
  input  logic [NCORE*LOCK_W-1:0] lock_adr,
  input  logic [NCORE-1:0]        lock_en,
  input  logic [NCORE-1:0]        unlock_en,
  output logic [NCORE-1:0]        lock_ac,
  output logic [ADR_W-1:0]        mem_adr,
  output logic [DAT_W-1:0]        mem_wdat,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [DAT_W-1:0]        mem_rdat
);
  localparam int ID_W  = $clog2(NCORE);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ID_W-1:0]  id, id_d, rr_ptr, rr_ptr_d, pick;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d, rdat_d;
  logic             op_write, op_write_d;
  logic [NCORE-1:0] req_any;

  assign req_any  = req_read | req_write;
  assign pick     = ID_W'(rr_pick(MAX_CORE'(req_any), 3'(rr_ptr), NCORE));
  assign mem_adr  = adr_q;
  assign mem_wdat = wdat_q;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    id_d       = id;
    rr_ptr_d   = rr_ptr;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    op_write_d = op_write;
    rdat_d     = rdat;
    ac         = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_any) begin
          id_d       = pick;
          adr_d      = req_adr[pick*ADR_W +: ADR_W];
          wdat_d     = req_wdat[pick*DAT_W +: DAT_W];
          op_write_d = req_write[pick];   // write wins over a simultaneous read
          cnt_d      = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        mem_we = op_write;
        mem_re = ~op_write;
        cnt_d  = cnt + 1'b1;
        if (cnt == CNT_W'(MEM_LAT - 1)) begin
          if (!op_write) rdat_d = mem_rdat;
          state_d = DONE;
        end
      end
      DONE: begin
        ac[id]   = 1'b1;
        rr_ptr_d = (id == ID_W'(NCORE - 1)) ? '0 : id + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      id       <= '0;
      rr_ptr   <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      op_write <= 1'b0;
      rdat     <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      id       <= id_d;
      rr_ptr   <= rr_ptr_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      op_write <= op_write_d;
      rdat     <= rdat_d;
    end
  end

  lock_table #(.NCORE(NCORE), .LOCK_W(LOCK_W)) u_lock_table (
    .clk       (clk),
    .reset     (reset),
    .lock_adr  (lock_adr),
    .lock_en   (lock_en),
    .unlock_en (unlock_en),
    .lock_ac   (lock_ac)
  );
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port main memory and a 16-entry lock table between NCORE pipelined cores.
- Each core's mainmem stage issues read/write requests and lock/unlock operations.
- The block grants memory round-robin, sequences the fixed-latency memory access, and returns one-cycle acknowledge pulses.
- It sits at the top level, between the core instances and the main memory macro.

Parameters:
NCORE, 2, number of requesting cores (2..8)
MEM_LAT, 2, memory access cycles per request (>=1)
LOCK_W, 4, lock address width; table holds 2**LOCK_W entries

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_read  in  NCORE  per-core read request, level, held until ac
req_write  in  NCORE  per-core write request, level, held until ac
req_adr  in  NCORE*16  per-core address, slice i = core i
req_wdat  in  NCORE*16  per-core write data
ac  out  NCORE  one-cycle access-done pulse per core
rdat  out  16  read data, valid in the ac cycle, broadcast to all cores
lock_adr  in  NCORE*LOCK_W  per-core lock index
lock_en  in  NCORE  per-core acquire request, level
unlock_en  in  NCORE  per-core release, single-cycle pulse
lock_ac  out  NCORE  one-cycle acquire-granted pulse
mem_adr  out  16  memory address
mem_wdat  out  16  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_rdat  in  16  memory read data, valid in the last MEM_LAT cycle

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0, cnt=0.
  - All lock entries free.
  - ac, lock_ac, mem_we, mem_re = 0; rdat, mem_adr, mem_wdat = 0.
  - Reset mid-access aborts the access; no ac is ever issued for it.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: requester set = req_read|req_write. If non-empty, grant the first requester scanning rr_ptr, rr_ptr+1, … mod NCORE. Latch its id, adr, wdat and op into registers, then go to ACCESS with cnt=0.
  - ACCESS: mem_adr/mem_wdat come from the latched registers. mem_we=op_write or mem_re=op_read for exactly MEM_LAT cycles. On cnt==MEM_LAT-1, capture mem_rdat (reads only) into rdat and go to DONE.
  - DONE: ac[id]=1 for this one cycle. rr_ptr = id+1 mod NCORE. Go to IDLE.
- Op selection: if the same core asserts both req_read and req_write, the write wins and the read is ignored.
- Latency: a request first seen in IDLE at cycle t produces memory enable at t+1..t+MEM_LAT and ac at t+MEM_LAT+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Requesters drop their request in the cycle after ac. Because IDLE follows DONE, a request held one extra cycle is re-granted as a new access; this is legal but a core bug.
- Request changes while in ACCESS have no effect; the latched values are used.
- Lock table: each entry holds valid plus owner[$clog2(NCORE)]. Evaluated every cycle, independent of the FSM.
  - Unlock first: unlock_en[i] with owner==i on lock_adr[i] clears the entry. Unlock by a non-owner, or of a free entry, is ignored.
  - Acquire second, using post-unlock state: lock_en[i] on a free entry, or on one already owned by i, sets valid with owner=i. lock_ac[i] is registered, high the next cycle for one cycle.
  - Multiple cores acquiring the same free entry in the same cycle: the lowest core index wins; the losers keep lock_en asserted and retry.
  - While lock_en[i] stays high after a grant, re-grant pulses are suppressed. lock_ac pulses once per rising edge of lock_en.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum (IDLE, ACCESS, DONE); ADR_W=16 and DAT_W=16 constants; function rr_pick(req, ptr) returning the grant index.
- Sub-module lock_table (NCORE, LOCK_W): owns the entry array, unlock/acquire priority and lock_ac generation.
- mem_arbiter instantiates lock_table plus the FSM.

Test Plan:
- Single read, MEM_LAT=2: core0 reads adr 0x0010 where memory holds 0xBEEF. Required: mem_re high 2 cycles; ac[0] pulses 3 cycles after the request was sampled; rdat=0xBEEF in that cycle.
- Contention: core0 and core1 both write (0x0001←0x1111, 0x0002←0x2222) from reset. Required: core0 served first, then core1. Next simultaneous requests: core0 then core1 again, because rr_ptr has returned to 0. Memory then holds both values.
- Read+write same core: core1 asserts both at adr 0x0005 with wdat 0x00AA. Required: only mem_we pulses; memory[5]=0x00AA; a single ac[1].
- Lock race: both cores lock_en on index 3 in the same cycle. Required: lock_ac[0] next cycle, no lock_ac[1]. After core0 unlock_en on index 3, core1 gets lock_ac[1] the following cycle.
- Non-owner unlock: core1 unlock_en on index 3 owned by core0. Required: the entry stays owned; a core1 lock_en on index 3 gets no lock_ac.
- Reset mid-access: drop reset during ACCESS. Required: no ac; mem_re/mem_we=0 immediately; all locks free; after release, a new request is served normally.
